// File: rtl/limbus_cpu_oci_trace_capture.sv
// OCI trace capture buffer: stores qualified trace words during a test, then drains them oldest-first.
// Optional build macro LIMBUS_OCI_TRACE_TSTAMP_EN adds a 16-bit write-cycle timestamp per entry (rd_tstamp).
module limbus_cpu_oci_trace_capture #(
   parameter int ENTRY_W   = 30,
   parameter int CNT_W     = 4,
   parameter int DEPTH     = 16,
   parameter int WRAP_MODE = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ENTRY_W-1:0]         dct_buffer,
   input  logic [CNT_W-1:0]           dct_count,
   input  logic                       dct_valid,
   input  logic                       test_ending,
   input  logic                       test_has_ended,
   output logic [ENTRY_W+CNT_W-1:0]   rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic [AW:0]                fill_level,
   output logic                       overflow,
   output logic [1:0]                 state,
   output logic                       done
`ifdef LIMBUS_OCI_TRACE_TSTAMP_EN
   ,
   output logic [15:0]                rd_tstamp
`endif
);

   typedef enum logic [1:0] {
      ST_CAPTURE = 2'd0,
      ST_FROZEN  = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   state_e                     state_q, state_d;
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
   logic [AW:0]                fill_q, fill_d;
   logic                       overflow_q, overflow_d;
   logic                       mem_we;
   logic                       write_req;
   logic                       full;
   logic                       pop;
   logic                       rd_valid_int;
   logic [ENTRY_W+CNT_W-1:0]   mem_q [DEPTH];

   assign write_req    = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
   assign full         = (fill_q == FULL_LEVEL);
   assign rd_valid_int = (state_q == ST_DRAIN) && (fill_q != '0);
   assign pop          = rd_valid_int && rd_ready;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      overflow_d = overflow_q;
      mem_we     = 1'b0;

      // When wrapping on a full buffer the write slot is the oldest entry, so both pointers step together.
      if (write_req) begin
         if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            fill_d   = fill_q + 1'b1;
         end else begin
            overflow_d = 1'b1;
            if (WRAP_MODE != 0) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         fill_d   = fill_q - 1'b1;
      end

      case (state_q)
         ST_CAPTURE: begin
            if (test_has_ended) begin
               state_d = ST_DRAIN;
            end else if (test_ending) begin
               state_d = ST_FROZEN;
            end
         end
         ST_FROZEN: begin
            if (test_has_ended) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if ((fill_q == '0) || (pop && (fill_q == (AW+1)'(1)))) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_DONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_CAPTURE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately left uninitialised by reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         mem_q[wr_ptr_q] <= {dct_count, dct_buffer};
      end
   end

`ifdef LIMBUS_OCI_TRACE_TSTAMP_EN
   logic [15:0] tstamp_q, tstamp_d;
   logic [15:0] ts_mem_q [DEPTH];

   always_comb begin
      tstamp_d = tstamp_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tstamp_q <= '0;
      end else begin
         tstamp_q <= tstamp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         ts_mem_q[wr_ptr_q] <= tstamp_q;
      end
   end

   assign rd_tstamp = ts_mem_q[rd_ptr_q];
`endif

   assign rd_data    = mem_q[rd_ptr_q];
   assign rd_valid   = rd_valid_int;
   assign fill_level = fill_q;
   assign overflow   = overflow_q;
   assign state      = state_q;
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_limbus_cpu_oci_trace_capture.sv
// Self-checking bench: a WRAP_MODE=1 and a WRAP_MODE=0 instance share stimulus and are compared
// every cycle against a list-based model, plus literal expectations for each directed scenario.
module tb_limbus_cpu_oci_trace_capture;

   logic        clk;
   logic        reset;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        dct_valid;
   logic        test_ending;
   logic        test_has_ended;
   logic        rd_ready;

   logic [33:0] rd0, rd1;
   logic        rv0, rv1;
   logic [4:0]  fl0, fl1;
   logic        ov0, ov1;
   logic [1:0]  st0, st1;
   logic        dn0, dn1;
`ifdef LIMBUS_OCI_TRACE_TSTAMP_EN
   logic [15:0] ts0, ts1;
`endif

   int checks   = 0;
   int failures = 0;
   bit live     = 0;

   // Model: oldest entry at index 0 of each list
   logic [33:0] mdata [2][16];
   int          msize [2];
   int          mst   [2];
   bit          movf  [2];

   logic [33:0] dr0[$];
   logic [33:0] dr1[$];

   limbus_cpu_oci_trace_capture #(.WRAP_MODE(1)) dut_wrap (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .rd_data(rd0), .rd_valid(rv0), .rd_ready(rd_ready), .fill_level(fl0),
      .overflow(ov0), .state(st0), .done(dn0)
`ifdef LIMBUS_OCI_TRACE_TSTAMP_EN
      , .rd_tstamp(ts0)
`endif
   );

   limbus_cpu_oci_trace_capture #(.WRAP_MODE(0)) dut_drop (
      .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
      .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
      .rd_data(rd1), .rd_valid(rv1), .rd_ready(rd_ready), .fill_level(fl1),
      .overflow(ov1), .state(st1), .done(dn1)
`ifdef LIMBUS_OCI_TRACE_TSTAMP_EN
      , .rd_tstamp(ts1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [33:0] ent(input int i);
      logic [3:0]  c;
      logic [29:0] b;
      c = 4'((i % 15) + 1);
      b = 30'(i);
      return {c, b};
   endfunction

   task automatic apply_stimulus(input bit v, input logic [29:0] b, input logic [3:0] c,
                                 input bit te, input bit th, input bit rr, input bit rst);
      dct_valid      = v;
      dct_buffer     = b;
      dct_count      = c;
      test_ending    = te;
      test_has_ended = th;
      rd_ready       = rr;
      reset          = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input bit rr, input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 30'd0, 4'd0, 0, 0, rr, 0);
   endtask

   task automatic do_reset();
      apply_stimulus(0, 30'd0, 4'd0, 0, 0, 0, 1);
      dr0.delete();
      dr1.delete();
   endtask

   // Compare at negedge, then advance the model to what the next rising edge must produce
   initial begin
      forever begin
         @(negedge clk);
         if (live) begin
            check_output("w_state", 64'(st0), 64'(mst[0]));
            check_output("w_fill", 64'(fl0), 64'(msize[0]));
            check_output("w_ovf", 64'(ov0), 64'(movf[0]));
            check_output("w_rvalid", 64'(rv0), 64'(mst[0] == 2 && msize[0] != 0));
            check_output("w_done", 64'(dn0), 64'(mst[0] == 3));
            if (mst[0] == 2 && msize[0] != 0) check_output("w_rdata", 64'(rd0), 64'(mdata[0][0]));
            check_output("d_state", 64'(st1), 64'(mst[1]));
            check_output("d_fill", 64'(fl1), 64'(msize[1]));
            check_output("d_ovf", 64'(ov1), 64'(movf[1]));
            check_output("d_rvalid", 64'(rv1), 64'(mst[1] == 2 && msize[1] != 0));
            check_output("d_done", 64'(dn1), 64'(mst[1] == 3));
            if (mst[1] == 2 && msize[1] != 0) check_output("d_rdata", 64'(rd1), 64'(mdata[1][0]));
            if (rv0 === 1'b1 && rd_ready) dr0.push_back(rd0);
            if (rv1 === 1'b1 && rd_ready) dr1.push_back(rd1);
         end
         if (reset) begin
            live = 1;
            for (int w = 0; w < 2; w++) begin
               msize[w] = 0;
               mst[w]   = 0;
               movf[w]  = 0;
            end
         end else if (live) begin
            for (int w = 0; w < 2; w++) begin
               case (mst[w])
                  0: begin
                     if (dct_valid && dct_count != 0) begin
                        if (msize[w] < 16) begin
                           mdata[w][msize[w]] = {dct_count, dct_buffer};
                           msize[w]++;
                        end else begin
                           movf[w] = 1;
                           if (w == 0) begin
                              for (int k = 0; k < 15; k++) mdata[w][k] = mdata[w][k+1];
                              mdata[w][15] = {dct_count, dct_buffer};
                           end
                        end
                     end
                     if (test_has_ended) mst[w] = 2;
                     else if (test_ending) mst[w] = 1;
                  end
                  1: if (test_has_ended) mst[w] = 2;
                  2: begin
                     if (msize[w] == 0) mst[w] = 3;
                     else if (rd_ready) begin
                        for (int k = 0; k < 15; k++) mdata[w][k] = mdata[w][k+1];
                        msize[w]--;
                        if (msize[w] == 0) mst[w] = 3;
                     end
                  end
                  default: mst[w] = 3;
               endcase
            end
         end
      end
   end

   initial begin
      dct_valid = 0; dct_buffer = '0; dct_count = '0;
      test_ending = 0; test_has_ended = 0; rd_ready = 0; reset = 1;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] scenario: five entries drained in order");
      do_reset();
      check_output("reset_state", 64'(st0), 64'd0);
      check_output("reset_fill", 64'(fl0), 64'd0);
      for (int i = 1; i <= 5; i++) apply_stimulus(1, 30'(100 + i), 4'(i), 0, 0, 0, 0);
      check_output("five_fill", 64'(fl0), 64'd5);
      apply_stimulus(0, 30'd0, 4'd0, 1, 0, 1, 0);
      check_output("frozen_state", 64'(st0), 64'd1);
      check_output("frozen_rvalid", 64'(rv0), 64'd0);
      apply_stimulus(0, 30'd0, 4'd0, 0, 1, 1, 0);
      idle(1, 8);
      check_output("five_popcount", 64'(dr0.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         check_output("five_order", 64'(i < dr0.size() ? dr0[i] : '1), 64'({4'(i + 1), 30'(101 + i)}));
      check_output("five_done", 64'(dn0), 64'd1);
      check_output("five_ovf", 64'(ov0), 64'd0);

      $display("[TB] scenario: twenty writes into sixteen slots");
      do_reset();
      for (int i = 0; i < 20; i++) apply_stimulus(1, 30'(i), 4'((i % 15) + 1), 0, 0, 0, 0);
      check_output("wrap_fill", 64'(fl0), 64'd16);
      check_output("wrap_ovf", 64'(ov0), 64'd1);
      check_output("drop_fill", 64'(fl1), 64'd16);
      check_output("drop_ovf", 64'(ov1), 64'd1);
      apply_stimulus(0, 30'd0, 4'd0, 0, 1, 1, 0);
      idle(1, 20);
      check_output("wrap_popcount", 64'(dr0.size()), 64'd16);
      check_output("drop_popcount", 64'(dr1.size()), 64'd16);
      for (int k = 0; k < 16; k++) begin
         check_output("wrap_order", 64'(k < dr0.size() ? dr0[k] : '1), 64'(ent(k + 4)));
         check_output("drop_order", 64'(k < dr1.size() ? dr1[k] : '1), 64'(ent(k)));
      end

      $display("[TB] scenario: zero-count and frozen writes");
      do_reset();
      apply_stimulus(1, 30'd7, 4'd0, 0, 0, 0, 0);
      check_output("zero_cnt_fill", 64'(fl0), 64'd0);
      apply_stimulus(1, 30'd8, 4'd2, 0, 0, 0, 0);
      apply_stimulus(1, 30'd9, 4'd3, 1, 0, 0, 0);
      apply_stimulus(1, 30'd10, 4'd4, 0, 0, 0, 0);
      apply_stimulus(0, 30'd0, 4'd0, 1, 0, 0, 0);
      check_output("frozen_fill", 64'(fl0), 64'd2);
      apply_stimulus(0, 30'd0, 4'd0, 0, 1, 1, 0);
      idle(1, 4);
      check_output("frozen_popcount", 64'(dr0.size()), 64'd2);
      check_output("ending_cycle_entry", 64'(dr0.size() > 1 ? dr0[1] : '1), 64'({4'd3, 30'd9}));

      $display("[TB] scenario: stalled drain");
      do_reset();
      for (int i = 0; i < 3; i++) apply_stimulus(1, 30'(20 + i), 4'd1, 0, 0, 0, 0);
      apply_stimulus(0, 30'd0, 4'd0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(0, 30'd0, 4'd0, 0, 0, 0, 0);
         check_output("stall_hold", 64'(rd0), 64'({4'd1, 30'(20 + i)}));
         apply_stimulus(0, 30'd0, 4'd0, 0, 0, 1, 0);
      end
      check_output("stall_popcount", 64'(dr0.size()), 64'd3);
      check_output("stall_state_done", 64'(st0), 64'd3);
      idle(0, 2);

      $display("[TB] scenario: reset in the middle of a drain");
      do_reset();
      for (int i = 0; i < 4; i++) apply_stimulus(1, 30'(40 + i), 4'd5, 0, 0, 0, 0);
      apply_stimulus(0, 30'd0, 4'd0, 0, 1, 0, 0);
      idle(1, 2);
      check_output("middrain_fill", 64'(fl0), 64'd2);
      apply_stimulus(1, 30'd50, 4'd6, 1, 1, 1, 1);
      check_output("mid_reset_state", 64'(st0), 64'd0);
      check_output("mid_reset_fill", 64'(fl0), 64'd0);
      check_output("mid_reset_rvalid", 64'(rv0), 64'd0);
      check_output("mid_reset_done", 64'(dn0), 64'd0);
      apply_stimulus(1, 30'd51, 4'd7, 0, 0, 0, 0);
      check_output("restart_fill", 64'(fl0), 64'd1);
      idle(0, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/limbus_cpu_oci_trace_capture.md
LIMBUS_CPU_OCI_TRACE_CAPTURE -- requirements
Module: limbus_cpu_oci_trace_capture

Interface
REQ-001 Parameter ENTRY_W, default 30: width of dct_buffer trace word.
REQ-002 Parameter CNT_W, default 4: width of dct_count.
REQ-003 Parameter DEPTH, default 16: capture entries, power of two, 2..256; AW = log2(DEPTH).
REQ-004 Parameter WRAP_MODE, default 1: 1 = overwrite oldest when full, 0 = drop newest when full.
REQ-005 clk  in  1  sole clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dct_buffer  in  ENTRY_W  trace word from OCI debug logic.
REQ-008 dct_count  in  CNT_W  number of valid trace slots in dct_buffer.
REQ-009 dct_valid  in  1  qualifies dct_buffer/dct_count this cycle.
REQ-010 test_ending  in  1  single-cycle pulse; stop capture.
REQ-011 test_has_ended  in  1  single-cycle pulse; start readout.
REQ-012 rd_data  out  ENTRY_W+CNT_W  oldest stored entry, {dct_count, dct_buffer}.
REQ-013 rd_valid  out  1  rd_data valid.
REQ-014 rd_ready  in  1  consumer accepts rd_data.
REQ-015 fill_level  out  AW+1  stored entry count, 0..DEPTH.
REQ-016 overflow  out  1  sticky; a full-buffer write occurred.
REQ-017 state  out  2  CAPTURE=0, FROZEN=1, DRAIN=2, DONE=3.
REQ-018 done  out  1  high in DONE.

Function
REQ-019 Write condition: state==CAPTURE && dct_valid && dct_count!=0; writes with dct_count==0 are ignored.
REQ-020 Written entry is stored at the next edge; fill_level reflects it one cycle after the write cycle.
REQ-021 Full, WRAP_MODE=1: write overwrites oldest, read pointer advances, fill_level stays DEPTH, overflow set.
REQ-022 Full, WRAP_MODE=0: write discarded, contents unchanged, overflow set.
REQ-023 CAPTURE + test_ending -> FROZEN; a write in the same cycle is accepted.
REQ-024 CAPTURE + test_has_ended (with or without test_ending) -> DRAIN; a same-cycle write is accepted.
REQ-025 FROZEN: all writes ignored; test_has_ended -> DRAIN; test_ending ignored.
REQ-026 DRAIN: rd_valid = (fill_level!=0); pop on rd_valid && rd_ready; read pointer increments modulo DEPTH.
REQ-027 rd_data and rd_valid are driven combinationally from storage and the read pointer; rd_data stays stable while rd_valid && !rd_ready.
REQ-028 DRAIN with fill_level==0, or the cycle that pops the last entry -> DONE at the next edge.
REQ-029 DONE: rd_valid=0, done=1; all inputs except reset are ignored; the state persists until reset.
REQ-030 rd_valid is 0 in CAPTURE and FROZEN regardless of fill_level.
REQ-031 Pointers are AW bits wide and wrap naturally; fill_level saturates at DEPTH and never underflows.
REQ-032 A test_ending or test_has_ended pulse in a state that does not use it has no effect.

Reset
REQ-033 Reset clears pointers and sets fill_level=0, overflow=0, state=CAPTURE, rd_valid=0, done=0; the storage array is not cleared.
REQ-034 Reset during any state, including mid-DRAIN, discards all stored entries; capture restarts the cycle after reset deasserts.
REQ-035 Reset takes priority over every simultaneous input event.

Configuration
REQ-036 Macro LIMBUS_OCI_TRACE_TSTAMP_EN defined: a 16-bit free-running cycle counter (reset to 0, wraps) is stored with each entry.
REQ-037 With LIMBUS_OCI_TRACE_TSTAMP_EN, output port rd_tstamp[15:0] presents the counter value of the write cycle of the entry on rd_data.
REQ-038 Macro undefined: neither the counter, the timestamp storage nor rd_tstamp exists; all other behaviour is identical.

Verification
REQ-039 DEPTH=16, write 5 entries (count=1..5), test_ending, then test_has_ended, rd_ready=1 -> rd_data returns the 5 entries in order, then done=1 and overflow=0.
REQ-040 WRAP_MODE=1, DEPTH=16, write 20 entries 0..19 -> fill_level=16, overflow=1, drain returns 4..19.
REQ-041 WRAP_MODE=0, DEPTH=16, write 20 entries 0..19 -> fill_level=16, overflow=1, drain returns 0..15.
REQ-042 Write with dct_count=0, then a write in FROZEN -> fill_level unchanged; a write in the test_ending cycle is stored.
REQ-043 In DRAIN, toggle rd_ready 1/0 with 3 entries -> rd_data is held while stalled, each entry pops exactly once, DONE after the third pop.
REQ-044 Assert reset in DRAIN with 2 entries left -> next cycle state=0, fill_level=0, rd_valid=0, done=0.
